read_fifo: RTL and testbench
============================

// Module: read_fifo
// PURPOSE
//  Read side of the ping-pong frame buffer. Drains the two 16-bit frame FIFOs
//  (FIFO_1/FIFO_2) that the writer fills one 20 ms frame at a time. Frames
//  are read in strict alternation, starting with FIFO_1. Output is a framed
//  sample stream with start/end markers for the downstream correlation stage.
//  Reads are throttled by a downstream ready signal.
// PARAMETERS
//  DATA_W     16    sample width
//  FRAME_LEN  1000  samples per frame (= FIFO depth)
//  CNT_W      10    width of rd_cnt; must satisfy 2**CNT_W >= FRAME_LEN
// PORTS
//  clk            in   1       system clock, 50 MHz
//  rst_n          in   1       async active-low reset
//  rdfull_1       in   1       FIFO_1 full (complete frame present)
//  rdfull_2       in   1       FIFO_2 full
//  rdempty_1      in   1       FIFO_1 empty
//  rdempty_2      in   1       FIFO_2 empty
//  q_1            in   DATA_W  FIFO_1 read data, valid 1 cycle after rdreq_1
//  q_2            in   DATA_W  FIFO_2 read data, valid 1 cycle after rdreq_2
//  proc_ready     in   1       downstream can accept a sample
//  rdreq_1        out  1       FIFO_1 read request (combinational)
//  rdreq_2        out  1       FIFO_2 read request (combinational)
//  data_out       out  DATA_W  sample to correlation stage (registered)
//  data_valid     out  1       data_out valid, one-cycle qualifier
//  frame_start    out  1       with data_valid: first sample of frame
//  frame_end      out  1       with data_valid: last sample of frame
//  frame_sel      out  1       source of current frame (0 = FIFO_1, 1 = FIFO_2)
//  frame_err      out  1       1-cycle pulse: FIFO went empty mid-frame
// BEHAVIOUR
//  Reset: all outputs 0, state = IDLE, next_sel = 0, rd_cnt = 0.
//   Reset may assert at any time; pipeline contents are discarded.
//  States:
//   IDLE: if rdfull of the FIFO selected by next_sel -> READ, frame_sel <= next_sel.
//     The other FIFO's full flag is ignored, so frame order is preserved.
//   READ: rdreq_x = proc_ready & !rdempty_x & (rd_cnt < FRAME_LEN);
//     x = frame_sel, and the other rdreq is held at 0.
//     Each rdreq increments rd_cnt.
//     After the rdreq with rd_cnt == FRAME_LEN-1 -> FLUSH.
//     If rdempty_x = 1 while 0 < rd_cnt < FRAME_LEN (underrun): frame_err pulses,
//     rdreq stops, the frame is abandoned (no frame_end), and state -> FLUSH.
//   FLUSH: 2 cycles with no reads while the pipeline drains. Then rd_cnt <= 0,
//     next_sel <= ~frame_sel, -> IDLE.
//  Pipeline: rdreq at cycle t -> q_x sampled at end of t+1 -> data_out and
//   data_valid high during t+2. Fixed latency of 2 cycles.
//   The tags first (rd_cnt==0) and last (rd_cnt==FRAME_LEN-1) travel with rdreq.
//  data_out holds its last value when data_valid = 0.
//  proc_ready low: no new rdreq. Up to 2 samples already in flight still emerge,
//   so downstream must absorb 2 samples after deasserting ready.
//  rdreq is never asserted while the target's rdempty = 1 (no FIFO underflow).
//  Frame gaps: at least 3 idle cycles between frame_end and the next frame_start.
// TESTING
//  FIFO_1 full with 0..999, proc_ready=1 -> rdreq_1 for 1000 consecutive cycles;
//   data_out 0..999 at latency 2; frame_start on 0, frame_end on 999, frame_sel=0.
//  Both FIFOs full (FIFO_1 = 0xAAAA.., FIFO_2 = 0x5555..) -> FIFO_1 frame first,
//   then FIFO_2 with frame_sel=1; rdreq_1 and rdreq_2 never high together.
//  Only rdfull_2 high after reset -> no rdreq; block waits in IDLE for FIFO_1.
//  proc_ready toggled 1/0 every 4 cycles -> exactly 1000 valid samples, in order,
//   no gaps in value; at most 2 data_valid after each ready fall.
//  rdempty_1 forced high after 500 reads -> frame_err pulses once, no frame_end,
//   rdreq_1 drops; next frame is read from FIFO_2.
//  rst_n low at sample 300 of a frame -> outputs 0 in the same cycle; after release
//   the block waits for rdfull_1 with next_sel=0.

Source files
------------

// File: rtl/read_fifo.sv
// read_fifo: ping-pong frame reader draining two sample FIFOs alternately into a framed stream
module read_fifo #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1000,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdfull_1,
  input  logic              rdfull_2,
  input  logic              rdempty_1,
  input  logic              rdempty_2,
  input  logic [DATA_W-1:0] q_1,
  input  logic [DATA_W-1:0] q_2,
  input  logic              proc_ready,
  output logic              rdreq_1,
  output logic              rdreq_2,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_sel,
  output logic              frame_err
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  state_t state_q, state_d;
  logic sel_q, sel_d, nsel_q, nsel_d, fl_q, fl_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic v1_q, first1_q, last1_q, src1_q;
  logic dv_q, fs_q, fe_q;
  logic [DATA_W-1:0] dout_q;
  logic empty_x, full_x, rd, last_rd;
  always_comb begin
    empty_x = sel_q ? rdempty_2 : rdempty_1;
    full_x  = nsel_q ? rdfull_2 : rdfull_1;
    rd      = state_q == READ && proc_ready && !empty_x && int'(cnt_q) < FRAME_LEN;
    last_rd = rd && cnt_q == LAST;
    state_d = state_q;
    sel_d   = sel_q;
    nsel_d  = nsel_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (full_x) begin
        state_d = READ;
        sel_d   = nsel_q;
      end
      READ: begin
        cnt_d = rd ? cnt_q + 1'b1 : cnt_q;
        if (last_rd) state_d = FLUSH;
        else if (empty_x && cnt_q != '0) begin
          // underrun: abandon the frame, its tail never gets a frame_end
          err_d   = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        fl_d = !fl_q;
        if (fl_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          nsel_d  = !sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      nsel_q   <= 1'b0;
      fl_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      src1_q   <= 1'b0;
      dv_q     <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      nsel_q   <= nsel_d;
      fl_q     <= fl_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      v1_q     <= rd;
      first1_q <= cnt_q == '0;
      last1_q  <= last_rd;
      src1_q   <= sel_q;
      dv_q     <= v1_q;
      fs_q     <= v1_q && first1_q;
      fe_q     <= v1_q && last1_q;
      if (v1_q) dout_q <= src1_q ? q_2 : q_1;
    end
  assign rdreq_1     = rd && !sel_q;
  assign rdreq_2     = rd && sel_q;
  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign frame_sel   = sel_q;
  assign frame_err   = err_q;
endmodule

// File: tb/tb_read_fifo.sv
// tb_read_fifo: directed scoreboard bench for read_fifo with behavioural FIFO models
module tb_read_fifo;
  typedef struct {int due; logic [15:0] d; logic f; logic l; logic s;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rdfull_1, rdfull_2, rdempty_1, rdempty_2, proc_ready;
  logic [15:0] q_1 = '0, q_2 = '0;
  logic rdreq_1, rdreq_2, data_valid, frame_start, frame_end, frame_sel, frame_err;
  logic [15:0] data_out;
  logic [15:0] m1[$], m2[$];
  exp_t sb[$];
  int n, checks, failures, rcnt;
  int cnt_v, cnt_s, cnt_e, cnt_err, cnt_r1, cnt_r2, rd1_tot, first_r1, last_r1, first_r2, low_v;
  logic psel, rdy_cur;
  bit tog, kill1;
  always #5 clk = ~clk;
  read_fifo dut (
    .clk(clk), .rst_n(rst_n), .rdfull_1(rdfull_1), .rdfull_2(rdfull_2),
    .rdempty_1(rdempty_1), .rdempty_2(rdempty_2), .q_1(q_1), .q_2(q_2),
    .proc_ready(proc_ready), .rdreq_1(rdreq_1), .rdreq_2(rdreq_2),
    .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
    .frame_end(frame_end), .frame_sel(frame_sel), .frame_err(frame_err)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic upd();
    rdfull_1  = m1.size() == 1000;
    rdfull_2  = m2.size() == 1000;
    rdempty_1 = m1.size() == 0 || (kill1 && rd1_tot >= 500);
    rdempty_2 = m2.size() == 0;
  endtask
  task automatic clr();
    cnt_v = 0; cnt_s = 0; cnt_e = 0; cnt_err = 0; cnt_r1 = 0; cnt_r2 = 0;
    rd1_tot = 0; first_r1 = -1; last_r1 = -1; first_r2 = -1; low_v = 0;
  endtask
  task automatic cyc();
    logic r1, r2, s;
    exp_t e;
    @(negedge clk);
    r1 = rdreq_1;
    r2 = rdreq_2;
    rdy_cur = proc_ready;
    chk("rdreq_overlap", {31'b0, r1 & r2}, 0);
    chk("rdreq_on_empty", {31'b0, (r1 & rdempty_1) | (r2 & rdempty_2)}, 0);
    if (r1 || r2) begin
      s = r2;
      if (s != psel) rcnt = 0;
      e.due = n + 2;
      e.d = s ? (m2.size() > 0 ? m2[0] : 16'hxxxx) : (m1.size() > 0 ? m1[0] : 16'hxxxx);
      e.f = rcnt == 0;
      e.l = rcnt == 999;
      e.s = s;
      sb.push_back(e);
      rcnt++;
      psel = s;
      if (r1) begin
        cnt_r1++; rd1_tot++;
        if (first_r1 < 0) first_r1 = n;
        last_r1 = n;
      end
      if (r2) begin
        cnt_r2++;
        if (first_r2 < 0) first_r2 = n;
      end
    end
    @(posedge clk);
    #1;
    n++;
    if (r1 && m1.size() > 0) q_1 = m1.pop_front();
    if (r2 && m2.size() > 0) q_2 = m2.pop_front();
    upd();
    if (data_valid) begin
      cnt_v++;
      cnt_s += int'(frame_start);
      cnt_e += int'(frame_end);
      if (!rdy_cur) low_v++;
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("latency", n, e.due);
        chk("data", {16'b0, data_out}, {16'b0, e.d});
        chk("frame_start", {31'b0, frame_start}, {31'b0, e.f});
        chk("frame_end", {31'b0, frame_end}, {31'b0, e.l});
        chk("frame_sel", {31'b0, frame_sel}, {31'b0, e.s});
      end
    end else if (sb.size() > 0 && sb[0].due <= n) begin
      e = sb.pop_front();
      chk("missing_valid", 0, 1);
    end
    cnt_err += int'(frame_err);
    proc_ready = tog ? ((n / 4) % 2 == 0) : 1'b1;
    if (proc_ready && !rdy_cur) begin
      chk("drain_after_ready_fall", {31'b0, low_v <= 2}, 1);
      low_v = 0;
    end
  endtask
  function automatic logic [31:0] outs();
    return {8'b0, data_out, data_valid, frame_start, frame_end, frame_sel, frame_err, rdreq_1, rdreq_2};
  endfunction
  task automatic hard_reset();
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", outs(), 0);
    sb.delete();
    rcnt = 0;
    psel = 1'b0;
    repeat (3) cyc();
    chk("reset_held_outputs", outs(), 0);
    rst_n = 1'b1;
  endtask
  initial begin
    proc_ready = 1'b1;
    tog = 0; kill1 = 0; n = 0; checks = 0; failures = 0; rcnt = 0; psel = 1'b0;
    clr();
    upd();
    hard_reset();
    clr();
    for (int i = 0; i < 1000; i++) m1.push_back(16'(i));
    upd();
    for (int i = 0; i < 1200 && cnt_e < 1; i++) cyc();
    repeat (4) cyc();
    chk("t1_frame_end", cnt_e, 1);
    chk("t1_frame_start", cnt_s, 1);
    chk("t1_samples", cnt_v, 1000);
    chk("t1_reads", cnt_r1, 1000);
    chk("t1_burst_len", last_r1 - first_r1 + 1, 1000);
    chk("t1_no_fifo2", cnt_r2, 0);
    chk("t1_drained", sb.size(), 0);
    hard_reset();
    clr();
    for (int i = 0; i < 1000; i++) m2.push_back(16'h5555);
    upd();
    repeat (50) cyc();
    chk("t3_no_read1", cnt_r1, 0);
    chk("t3_no_read2", cnt_r2, 0);
    chk("t3_no_valid", cnt_v, 0);
    chk("t3_sel", {31'b0, frame_sel}, 0);
    for (int i = 0; i < 1000; i++) m1.push_back(16'hAAAA);
    upd();
    for (int i = 0; i < 2500 && cnt_e < 2; i++) cyc();
    repeat (4) cyc();
    chk("t2_frame_ends", cnt_e, 2);
    chk("t2_frame_starts", cnt_s, 2);
    chk("t2_reads1", cnt_r1, 1000);
    chk("t2_reads2", cnt_r2, 1000);
    chk("t2_order", {31'b0, first_r2 > last_r1}, 1);
    chk("t2_samples", cnt_v, 2000);
    clr();
    for (int i = 0; i < 1000; i++) m1.push_back(16'h1000 + 16'(i));
    upd();
    tog = 1;
    for (int i = 0; i < 3000 && cnt_e < 1; i++) cyc();
    tog = 0;
    repeat (4) cyc();
    chk("t4_samples", cnt_v, 1000);
    chk("t4_frame_end", cnt_e, 1);
    chk("t4_reads", cnt_r1, 1000);
    hard_reset();
    clr();
    kill1 = 1;
    for (int i = 0; i < 1000; i++) m1.push_back(16'h2000 + 16'(i));
    for (int i = 0; i < 1000; i++) m2.push_back(16'h5000 + 16'(i));
    upd();
    for (int i = 0; i < 2500 && cnt_e < 1; i++) cyc();
    repeat (4) cyc();
    chk("t5_frame_err", cnt_err, 1);
    chk("t5_reads1", cnt_r1, 500);
    chk("t5_reads2", cnt_r2, 1000);
    chk("t5_frame_end", cnt_e, 1);
    chk("t5_frame_start", cnt_s, 2);
    chk("t5_samples", cnt_v, 1500);
    kill1 = 0;
    m1.delete();
    upd();
    hard_reset();
    clr();
    for (int i = 0; i < 1000; i++) m1.push_back(16'h3000 + 16'(i));
    upd();
    for (int i = 0; i < 400 && cnt_v < 300; i++) cyc();
    chk("t6_reached_300", cnt_v, 300);
    hard_reset();
    clr();
    for (int i = 0; i < 1000; i++) m2.push_back(16'h4000 + 16'(i));
    upd();
    repeat (50) cyc();
    chk("t6_waits_fifo1", cnt_r1 + cnt_r2, 0);
    chk("t6_sel", {31'b0, frame_sel}, 0);
    m1.delete();
    for (int i = 0; i < 1000; i++) m1.push_back(16'h6000 + 16'(i));
    upd();
    for (int i = 0; i < 1200 && cnt_e < 1; i++) cyc();
    chk("t6_resume_fifo1", cnt_r1, 1000);
    chk("t6_resume_no_fifo2", cnt_r2, 0);
    chk("t6_resume_end", cnt_e, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
